// File: rtl/ball_pkg.sv
// Shared types for the ball scan controller: colour classes, coordinate widths,
// frame/line FSM states and the run descriptor passed between tracker and top.
package ball_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int MIN_RUN_DEF   = 4;
  localparam int BLACK_GAP_DEF = 3;

  typedef enum logic [2:0] {
    C_VOID   = 3'd0,
    C_RED    = 3'd1,
    C_BLUE   = 3'd2,
    C_YELLOW = 3'd3,
    C_BLACK  = 3'd4
  } color_e;

  typedef enum logic [1:0] {F_IDLE, F_SCAN, F_REPORT} frame_state_e;
  typedef enum logic [1:0] {L_OUT, L_RUN, L_GAP} line_state_e;

  typedef struct packed {
    logic           vld;
    logic [X_W-1:0] start;
    logic [X_W-1:0] last;
  } run_t;

  function automatic logic [X_W-1:0] x_inc(input logic [X_W-1:0] x);
    return (x == '1) ? x : x + X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] y_inc(input logic [Y_W-1:0] y);
    return (y == '1) ? y : y + Y_W'(1);
  endfunction

endpackage

// File: rtl/ball_scan_ctrl_if.sv
// Pixel-stream inputs and result handshake of the ball scan controller.
interface ball_scan_ctrl_if;

  logic                      frame_start;
  logic                      frame_end;
  logic                      line_start;
  logic                      pix_valid;
  logic [2:0]                pix_color;
  logic [2:0]                target_color;
  logic                      res_valid;
  logic                      res_ready;
  logic                      res_found;
  logic [ball_pkg::X_W-1:0]  res_x_min;
  logic [ball_pkg::X_W-1:0]  res_x_max;
  logic [ball_pkg::Y_W-1:0]  res_y_min;
  logic [ball_pkg::Y_W-1:0]  res_y_max;
  logic                      busy;

  modport slave (
    input  frame_start, frame_end, line_start, pix_valid, pix_color, target_color, res_ready,
    output res_valid, res_found, res_x_min, res_x_max, res_y_min, res_y_max, busy
  );

  modport master (
    output frame_start, frame_end, line_start, pix_valid, pix_color, target_color, res_ready,
    input  res_valid, res_found, res_x_min, res_x_max, res_y_min, res_y_max, busy
  );

endinterface

// File: rtl/ball_run_tracker.sv
// Per-line run tracker: follows target-colour runs with short BLACK gaps and keeps the
// longest qualifying run; fin_o is the line best with the open run already closed.
module ball_run_tracker
  import ball_pkg::*;
#(
  parameter int MIN_RUN   = MIN_RUN_DEF,
  parameter int BLACK_GAP = BLACK_GAP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           pix_en_i,
  input  logic           pix_match_i,
  input  logic           pix_black_i,
  input  logic [X_W-1:0] pix_x_i,
  output run_t           fin_o
);

  localparam int GAP_W = $clog2(BLACK_GAP + 1);
  localparam logic [X_W:0]   MIN_W   = MIN_RUN[X_W:0];
  localparam logic [GAP_W-1:0] GAP_MAX = BLACK_GAP[GAP_W-1:0];

  line_state_e      state_q, state_d;
  run_t             best_q, best_d;
  logic [X_W-1:0]   run_start_q, run_start_d;
  logic [X_W-1:0]   run_last_q, run_last_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  // Candidate replaces the best only when strictly longer, so ties keep the earlier run.
  function automatic run_t close_run(input run_t best, input logic [X_W-1:0] rs,
                                     input logic [X_W-1:0] rl);
    logic [X_W:0] w;
    logic [X_W:0] bw;
    w  = {1'b0, rl} - {1'b0, rs} + (X_W+1)'(1);
    bw = {1'b0, best.last} - {1'b0, best.start} + (X_W+1)'(1);
    if (w >= MIN_W && (!best.vld || w > bw)) return '{vld: 1'b1, start: rs, last: rl};
    return best;
  endfunction

  line_state_e st;
  run_t        base_best;

  always_comb begin
    st          = clr_i ? L_OUT : state_q;
    base_best   = clr_i ? '0 : best_q;
    state_d     = st;
    best_d      = base_best;
    run_start_d = run_start_q;
    run_last_d  = run_last_q;
    gap_d       = gap_q;
    if (pix_en_i) begin
      case (st)
        L_OUT: if (pix_match_i) begin
          state_d     = L_RUN;
          run_start_d = pix_x_i;
          run_last_d  = pix_x_i;
        end
        L_RUN: if (pix_match_i) begin
          run_last_d = pix_x_i;
        end else if (pix_black_i) begin
          state_d = L_GAP;
          gap_d   = GAP_W'(1);
        end else begin
          best_d  = close_run(base_best, run_start_q, run_last_q);
          state_d = L_OUT;
        end
        L_GAP: if (pix_match_i) begin
          state_d    = L_RUN;
          run_last_d = pix_x_i;
        end else if (pix_black_i && gap_q != GAP_MAX) begin
          gap_d = gap_q + GAP_W'(1);
        end else begin
          best_d  = close_run(base_best, run_start_q, run_last_q);
          state_d = L_OUT;
        end
        default: state_d = L_OUT;
      endcase
    end
  end

  assign fin_o = (state_q == L_OUT) ? best_q : close_run(best_q, run_start_q, run_last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= L_OUT;
      best_q      <= '0;
      run_start_q <= '0;
      run_last_q  <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      run_start_q <= run_start_d;
      run_last_q  <= run_last_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: rtl/ball_scan_ctrl.sv
// Frame FSM, x/y counters and bbox merge; result registered 1 cycle after frame_end and
// held in F_REPORT until res_ready, during which new frames are dropped.
module ball_scan_ctrl
  import ball_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int MIN_RUN   = MIN_RUN_DEF,
  parameter int BLACK_GAP = BLACK_GAP_DEF
) (
  input logic              clk,
  input logic              rst,
  ball_scan_ctrl_if.slave  bus
);

  localparam logic [X_W:0] H_LIM = H_ACTIVE[X_W:0];
  localparam logic [Y_W:0] V_LIM = V_ACTIVE[Y_W:0];

  frame_state_e   fstate_q;
  color_e         target_q;
  logic           line_vld_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [X_W-1:0] bx_min_q, bx_max_q;
  logic [Y_W-1:0] by_min_q, by_max_q;
  logic           found_q;
  logic           res_valid_q, res_found_q, busy_q;
  logic [X_W-1:0] res_x_min_q, res_x_max_q;
  logic [Y_W-1:0] res_y_min_q, res_y_max_q;

  logic           scan, begin_frame, lstart, close_line, trk_clr, pix_en, pix_match, pix_black;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic [X_W-1:0] mx_min, mx_max;
  logic [Y_W-1:0] my_min, my_max;
  logic           m_found;
  run_t           fin;

  assign scan        = (fstate_q == F_SCAN);
  assign begin_frame = bus.frame_start && ((fstate_q == F_IDLE) || (scan && !bus.frame_end));
  assign lstart      = scan && bus.line_start && !bus.frame_end && !bus.frame_start;

  // A pixel sharing the line_start cycle already belongs to the new line at x=0.
  assign pix_x = lstart ? '0 : x_q;
  assign pix_y = lstart ? (line_vld_q ? y_inc(y_q) : '0) : y_q;

  assign pix_en = scan && bus.pix_valid && !bus.frame_end && !bus.frame_start
                  && (lstart || line_vld_q)
                  && ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);

  assign pix_match = (target_q != C_VOID) && (target_q != C_BLACK)
                     && (bus.pix_color == target_q);
  assign pix_black = (bus.pix_color == C_BLACK);

  assign trk_clr    = begin_frame || (scan && (bus.frame_end || bus.line_start));
  assign close_line = scan && (bus.frame_end || lstart) && line_vld_q && fin.vld;

  ball_run_tracker #(
    .MIN_RUN   (MIN_RUN),
    .BLACK_GAP (BLACK_GAP)
  ) u_trk (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (trk_clr),
    .pix_en_i    (pix_en),
    .pix_match_i (pix_match),
    .pix_black_i (pix_black),
    .pix_x_i     (pix_x),
    .fin_o       (fin)
  );

  always_comb begin
    mx_min  = bx_min_q;
    mx_max  = bx_max_q;
    my_min  = by_min_q;
    my_max  = by_max_q;
    m_found = found_q;
    if (close_line) begin
      if (fin.start < bx_min_q) mx_min = fin.start;
      if (fin.last  > bx_max_q) mx_max = fin.last;
      if (y_q < by_min_q)       my_min = y_q;
      if (y_q > by_max_q)       my_max = y_q;
      m_found = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate_q    <= F_IDLE;
      target_q    <= C_VOID;
      line_vld_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      bx_min_q    <= '0;
      bx_max_q    <= '0;
      by_min_q    <= '0;
      by_max_q    <= '0;
      found_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_x_min_q <= '0;
      res_x_max_q <= '0;
      res_y_min_q <= '0;
      res_y_max_q <= '0;
      busy_q      <= 1'b0;
    end else if (begin_frame) begin
      fstate_q   <= F_SCAN;
      target_q   <= color_e'(bus.target_color);
      line_vld_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      bx_min_q   <= '1;
      bx_max_q   <= '0;
      by_min_q   <= '1;
      by_max_q   <= '0;
      found_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (fstate_q)
        F_SCAN: begin
          if (bus.frame_end) begin
            fstate_q    <= F_REPORT;
            res_valid_q <= 1'b1;
            res_found_q <= m_found;
            res_x_min_q <= m_found ? mx_min : '0;
            res_x_max_q <= m_found ? mx_max : '0;
            res_y_min_q <= m_found ? my_min : '0;
            res_y_max_q <= m_found ? my_max : '0;
          end else begin
            if (lstart) begin
              line_vld_q <= 1'b1;
              y_q        <= pix_y;
              bx_min_q   <= mx_min;
              bx_max_q   <= mx_max;
              by_min_q   <= my_min;
              by_max_q   <= my_max;
              found_q    <= m_found;
            end
            if (bus.pix_valid) x_q <= x_inc(pix_x);
            else if (lstart)   x_q <= '0;
          end
        end
        F_REPORT: if (bus.res_ready) begin
          fstate_q    <= F_IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: fstate_q <= F_IDLE;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_found = res_found_q;
  assign bus.res_x_min = res_x_min_q;
  assign bus.res_x_max = res_x_max_q;
  assign bus.res_y_min = res_y_min_q;
  assign bus.res_y_max = res_y_max_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ball_scan_ctrl.sv
// Directed frames for ball_scan_ctrl; expected bounding boxes are queued by the stimulus
// and popped by an independent monitor on each accepted result.
module tb_ball_scan_ctrl;
  import ball_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_scan_ctrl_if bus();

  ball_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] found;
    logic [31:0] xmin;
    logic [31:0] xmax;
    logic [31:0] ymin;
    logic [31:0] ymax;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_res(input int f, input int x0, input int x1, input int y0, input int y1);
    exp_t e;
    e.found = f; e.xmin = x0; e.xmax = x1; e.ymin = y0; e.ymax = y1;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus; pulses are removed just after the sampling edge.
  task automatic step(input logic fs, input logic fe, input logic ls, input logic pv,
                      input logic [2:0] col);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.line_start  = ls;
    bus.pix_valid   = pv;
    bus.pix_color   = col;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.line_start  = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_color   = C_VOID;
  endtask

  task automatic start_frame(input color_e tgt);
    bus.target_color = tgt;
    step(1'b1, 1'b0, 1'b0, 1'b0, C_VOID);
  endtask

  task automatic empty_lines(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, C_VOID);
  endtask

  task automatic line_begin(input color_e col);
    step(1'b0, 1'b0, 1'b1, 1'b1, col);
  endtask

  task automatic seg(input color_e col, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, col);
  endtask

  task automatic end_frame(input logic with_ls);
    chk("valid_before_end", bus.res_valid, 0);
    step(1'b0, 1'b1, with_ls, 1'b0, C_VOID);
    chk("res_latency", bus.res_valid, 1);
    chk("busy_report", bus.busy, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, C_VOID);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result found=%0d x=%0d..%0d y=%0d..%0d",
                   bus.res_found, bus.res_x_min, bus.res_x_max, bus.res_y_min, bus.res_y_max);
        end else begin
          e = exp_q.pop_front();
          chk("res_found", bus.res_found, e.found);
          chk("res_x_min", bus.res_x_min, e.xmin);
          chk("res_x_max", bus.res_x_max, e.xmax);
          chk("res_y_min", bus.res_y_min, e.ymin);
          chk("res_y_max", bus.res_y_max, e.ymax);
        end
      end
    end
  end

  initial begin : stimulus
    bus.frame_start  = 1'b0;
    bus.frame_end    = 1'b0;
    bus.line_start   = 1'b0;
    bus.pix_valid    = 1'b0;
    bus.pix_color    = C_VOID;
    bus.target_color = C_RED;
    bus.res_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_found", bus.res_found, 0);
    chk("rst_x_max", bus.res_x_max, 0);
    rst = 1'b0;

    // Single run on line 10
    start_frame(C_RED);
    chk("busy_scan", bus.busy, 1);
    empty_lines(10);
    line_begin(C_VOID); seg(C_VOID, 99); seg(C_RED, 20); seg(C_VOID, 5);
    expect_res(1, 100, 119, 10, 10);
    end_frame(1'b0);

    // Gap of 3 BLACK is bridged
    start_frame(C_RED);
    line_begin(C_VOID); seg(C_VOID, 49); seg(C_RED, 6); seg(C_BLACK, 3); seg(C_RED, 12);
    seg(C_VOID, 3);
    expect_res(1, 50, 70, 0, 0);
    end_frame(1'b0);

    // Gap of 4 BLACK splits; longer second run wins
    start_frame(C_RED);
    line_begin(C_VOID); seg(C_VOID, 49); seg(C_RED, 6); seg(C_BLACK, 4); seg(C_RED, 11);
    seg(C_VOID, 3);
    expect_res(1, 60, 70, 0, 0);
    end_frame(1'b0);

    // Run too short
    start_frame(C_RED);
    line_begin(C_VOID); seg(C_VOID, 9); seg(C_RED, 3); seg(C_VOID, 2);
    expect_res(0, 0, 0, 0, 0);
    end_frame(1'b0);

    // Multi-line merge; open runs closed by line_start and by frame_end
    start_frame(C_RED);
    empty_lines(5);
    line_begin(C_VOID); seg(C_VOID, 29); seg(C_RED, 11); seg(C_VOID, 2);
    line_begin(C_VOID); seg(C_VOID, 27); seg(C_RED, 17);
    line_begin(C_VOID); seg(C_VOID, 34); seg(C_RED, 5);
    expect_res(1, 28, 44, 5, 7);
    end_frame(1'b0);

    // Equal runs: earlier kept
    start_frame(C_RED);
    line_begin(C_VOID); seg(C_VOID, 9); seg(C_RED, 5); seg(C_VOID, 5); seg(C_RED, 5);
    seg(C_VOID, 1);
    expect_res(1, 10, 14, 0, 0);
    end_frame(1'b0);

    // Result held under backpressure; frame_start during hold ignored
    start_frame(C_BLUE);
    line_begin(C_BLUE); seg(C_BLUE, 7); seg(C_VOID, 1);
    line_begin(C_RED); seg(C_RED, 9);
    expect_res(1, 0, 7, 0, 0);
    bus.res_ready = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, C_VOID);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.target_color = C_RED;
        step(1'b1, 1'b0, 1'b0, 1'b0, C_VOID);
      end else begin
        step(1'b0, 1'b0, 1'b1, 1'b1, C_RED);
      end
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_found", bus.res_found, 1);
      chk("hold_x_max", bus.res_x_max, 7);
    end
    bus.res_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, C_VOID);
    chk("after_hs_busy", bus.busy, 0);
    chk("after_hs_valid", bus.res_valid, 0);

    // Reset mid-line discards the frame
    start_frame(C_RED);
    line_begin(C_RED); seg(C_RED, 9); seg(C_VOID, 1);
    line_begin(C_RED); seg(C_RED, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.res_valid, 0);
    start_frame(C_YELLOW);
    line_begin(C_VOID); seg(C_VOID, 2); seg(C_YELLOW, 6); seg(C_VOID, 1);
    line_begin(C_RED); seg(C_RED, 19);
    expect_res(1, 3, 8, 0, 0);
    end_frame(1'b0);

    // BLACK target never matches
    start_frame(C_BLACK);
    line_begin(C_BLACK); seg(C_BLACK, 9);
    expect_res(0, 0, 0, 0, 0);
    end_frame(1'b0);

    // frame_end with line_start: line closed once
    start_frame(C_RED);
    line_begin(C_VOID); seg(C_RED, 5);
    expect_res(1, 1, 5, 0, 0);
    end_frame(1'b1);

    // frame_start during scan restarts with a clear bbox
    start_frame(C_RED);
    line_begin(C_RED); seg(C_RED, 9); seg(C_VOID, 1);
    start_frame(C_RED);
    line_begin(C_VOID); seg(C_VOID, 19); seg(C_RED, 4); seg(C_VOID, 1);
    expect_res(1, 20, 23, 0, 0);
    end_frame(1'b0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
